pcs_tx_gb_n: RTL

PCS_TX_GB_N -- requirements
Module: pcs_tx_gb_n

---
 rtl/pcs_pkg.sv | 27 ++
 rtl/pcs_gb_lane.sv | 64 ++++++
 rtl/pcs_tx_gb_n.sv | 65 ++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared PCS constants: 64b/66b block geometry, sync headers and PRBS31 helpers.
package pcs_pkg;

    localparam int unsigned HEAD_W  = 2;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BLOCK_W = HEAD_W + DATA_W;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // PRBS31 polynomial x^31 + x^28 + 1
    localparam int unsigned PRBS_W     = 31;
    localparam int unsigned PRBS_TAP_A = 31;
    localparam int unsigned PRBS_TAP_B = 28;
    localparam logic [PRBS_W-1:0] PRBS_SEED = '1;

    // Per-lane seed: all-ones with the lane index folded into the low bits
    function automatic logic [PRBS_W-1:0] prbs_seed(input int unsigned lane);
        return PRBS_SEED ^ PRBS_W'(lane);
    endfunction

    // One PRBS31 step; bit 0 holds the oldest bit, the new bit enters at the top
    function automatic logic [PRBS_W-1:0] prbs31_step(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-PRBS_TAP_A] ^ s[PRBS_W-PRBS_TAP_B], s[PRBS_W-1:1]};
    endfunction

endpackage

// File: rtl/pcs_gb_lane.sv
// One gearbox lane: bit buffer with block insert / word extract, plus its PRBS31 source.
module pcs_gb_lane
    import pcs_pkg::*;
#(
    parameter int unsigned BLK_W    = 66,
    parameter int unsigned SERDES_W = 64,
    parameter int unsigned FILL_W   = 8,
    parameter int unsigned LANE_IDX = 0
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                ins,
    input  logic                prbs_en,
    input  logic [BLK_W-1:0]    blk,
    input  logic [FILL_W-1:0]   fill,
    output logic [SERDES_W-1:0] word
);

    localparam int unsigned BUF_W = SERDES_W + BLK_W;

    logic [BUF_W-1:0]    bits_q;
    logic [BUF_W-1:0]    merged;
    logic [BUF_W-1:0]    bits_next;
    logic [PRBS_W-1:0]   prbs_q;
    logic [PRBS_W-1:0]   prbs_next;
    logic [SERDES_W-1:0] prbs_word;

    // Append the new block behind the buffered bits, then drop the outgoing word
    always_comb begin
        merged = bits_q;
        if (ins) begin
            merged = bits_q | (BUF_W'(blk) << fill);
        end
        bits_next = merged >> SERDES_W;
    end

    // Advance the PRBS31 generator by one SerDes word, first bit to bit 0
    always_comb begin
        prbs_next = prbs_q;
        prbs_word = '0;
        for (int i = 0; i < SERDES_W; i++) begin
            prbs_next    = prbs31_step(prbs_next);
            prbs_word[i] = prbs_next[PRBS_W-1];
        end
    end

    // Buffer, PRBS state and output word; PRBS holds its state while disabled
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            bits_q <= '0;
            prbs_q <= prbs_seed(LANE_IDX);
            word   <= '0;
        end else begin
            bits_q <= bits_next;
            if (prbs_en) begin
                prbs_q <= prbs_next;
                word   <= prbs_word;
            end else begin
                word   <= merged[SERDES_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pcs_tx_gb_n.sv
// Multi-lane 66b -> SerDes-word transmit gearbox with a shared fill counter.
module pcs_tx_gb_n
    import pcs_pkg::*;
#(
    parameter int unsigned LANE_N   = 4,
    parameter int unsigned HEAD_W   = pcs_pkg::HEAD_W,
    parameter int unsigned DATA_W   = pcs_pkg::DATA_W,
    parameter int unsigned SERDES_W = 64
) (
    input  logic                         clk,
    input  logic                         nreset,
    input  logic                         valid_i,
    input  logic [LANE_N*HEAD_W-1:0]     head_i,
    input  logic [LANE_N*DATA_W-1:0]     data_i,
    output logic                         ready_o,
    input  logic                         prbs_en_i,
    output logic [LANE_N*SERDES_W-1:0]   serdes_data_o,
    output logic                         underflow_o
);

    localparam int unsigned BLK_W  = HEAD_W + DATA_W;
    localparam int unsigned FILL_W = $clog2(SERDES_W + BLK_W);

    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;

    // Take a block whenever fewer than one word of bits is buffered
    assign ready_o   = nreset && (fill_q < FILL_W'(SERDES_W));
    assign fill_next = fill_q + (ready_o ? FILL_W'(BLK_W) : FILL_W'(0)) - FILL_W'(SERDES_W);

    // Shared fill counter and underflow flag
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fill_q      <= '0;
            underflow_o <= 1'b0;
        end else begin
            fill_q      <= fill_next;
            underflow_o <= ready_o & ~valid_i;
        end
    end

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        logic [BLK_W-1:0] blk;

        // Header occupies the first-transmitted bits; a missing block is sent as zeros
        assign blk = valid_i ? {data_i[l*DATA_W +: DATA_W], head_i[l*HEAD_W +: HEAD_W]}
                             : '0;

        pcs_gb_lane #(
            .BLK_W    (BLK_W),
            .SERDES_W (SERDES_W),
            .FILL_W   (FILL_W),
            .LANE_IDX (l)
        ) u_lane (
            .clk     (clk),
            .nreset  (nreset),
            .ins     (ready_o),
            .prbs_en (prbs_en_i),
            .blk     (blk),
            .fill    (fill_q),
            .word    (serdes_data_o[l*SERDES_W +: SERDES_W])
        );
    end

endmodule
